shift_seq: RTL

Sequenced 8-bit shift engine for the lab datapath. It accepts a one-cycle command (mode, initial byte, shift amount), then performs the load and the required number of single-bit shift steps without further host involvement. It reports progress with `busy` and a one-cycle `done` pulse. It sits between the switch/key front end and the LED/seven-segment display logic, and replaces the hand-clocked shift register in multi-step demos.

---
 rtl/shift_seq_pkg.sv | 22 ++
 rtl/shift_unit.sv | 24 ++
 rtl/shift_seq.sv | 62 ++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the sequenced shift engine.
package shift_seq_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int AMT_W_DEF = 3;

  typedef enum logic [2:0] {
    MODE_CLEAR = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_LSR   = 3'd2,
    MODE_LSL   = 3'd3,
    MODE_ASR   = 3'd4,
    MODE_SER   = 3'd5,
    MODE_ROR   = 3'd6,
    MODE_ROL   = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/shift_unit.sv
// One combinational shift step of the selected mode.
module shift_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] nxt
);
  always_comb begin
    nxt = q;
    unique case (mode)
      MODE_LSR: nxt = {1'b0, q[WIDTH-1:1]};
      MODE_LSL: nxt = {q[WIDTH-2:0], 1'b0};
      MODE_ASR: nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_SER: nxt = {ser_in, q[WIDTH-1:1]};
      MODE_ROR: nxt = {q[0], q[WIDTH-1:1]};
      MODE_ROL: nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      default:  nxt = q;
    endcase
  end
endmodule

// File: rtl/shift_seq.sv
// Command-driven shift sequencer: load at the start edge, then `amount` single-bit steps.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  state_e           state;
  mode_e            mode_r;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] step_q;
  mode_e            mode_in;

  assign mode_in = mode_e'(mode);

  shift_unit #(.WIDTH(WIDTH)) u_step (
    .q      (q),
    .mode   (mode_r),
    .ser_in (ser_in),
    .nxt    (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_r <= MODE_CLEAR;
      cnt    <= '0;
      q      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          q      <= (mode_in == MODE_CLEAR) ? '0 : din;
          mode_r <= mode_in;
          cnt    <= amount;
          // CLEAR/LOAD and zero-length shifts finish right after the load edge
          state  <= (mode_in >= MODE_LSR && amount != '0) ? ST_SHIFT : ST_DONE;
        end
        ST_SHIFT: begin
          q   <= step_q;
          cnt <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
endmodule
